// File: rtl/sync_down_timer.sv
// Loadable synchronous down counter with one-shot and periodic (auto-reload) modes.
// The decrement uses a toggle-enable chain rather than a subtractor.
module sync_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_q,
    output logic             o_zero,
    output logic             o_busy,
    output logic             o_tc_pulse
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Bit i toggles on a decrement when every lower bit is zero.
    function automatic logic [WIDTH-1:0] f_toggle_mask(input logic [WIDTH-2:0] v);
        logic [WIDTH-1:0] t;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & ~v[i-1];
        end
        return t;
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;
    logic [WIDTH-1:0] w_toggle;

    // Next-state logic: load beats terminal, terminal beats a plain decrement.
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        w_toggle     = f_toggle_mask(r_q[WIDTH-2:0]);
        if (i_load) begin
            w_q_nxt      = i_load_val;
            w_reload_nxt = i_load_val;
            if (i_load_val != ZERO) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!i_en) begin
                        w_q_nxt = r_q;
                    end else if (r_q == ONE) begin
                        w_tc_nxt = 1'b1;
                        if (i_auto_reload) begin
                            w_q_nxt = r_reload;
                        end else begin
                            w_q_nxt     = ZERO;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (r_q == ZERO) begin
                        // Unreachable in normal use; never let RUN wrap past zero.
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_q_nxt = r_q ^ w_toggle;
                    end
                end
                ST_IDLE: begin
                    w_q_nxt = r_q;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_q      <= ZERO;
            r_reload <= ZERO;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    assign o_q        = r_q;
    assign o_zero     = (r_q == ZERO);
    assign o_busy     = (r_state == ST_RUN);
    assign o_tc_pulse = r_tc;

endmodule

// File: tb/tb_sync_down_timer.sv
// Self-checking bench: a per-cycle behavioural model for two widths plus
// hand-computed directed expectations.
module tb_sync_down_timer;

    logic       clk;
    logic       rst, load, en, ar;
    logic [7:0] lv;
    logic [7:0] q8;
    logic       zero8, busy8, tc8;
    logic       rst4, load4, en4, ar4;
    logic [3:0] lv4;
    logic [3:0] q4;
    logic       zero4, busy4, tc4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] q;
        logic        run;
        logic [31:0] rl;
        logic        tc;
    } m_t;

    m_t m8, m4;
    bit m_ok = 1'b0;

    sync_down_timer #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_load_val(lv),
        .i_auto_reload(ar), .o_q(q8), .o_zero(zero8), .o_busy(busy8), .o_tc_pulse(tc8)
    );

    sync_down_timer #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_en(en4), .i_load(load4), .i_load_val(lv4),
        .i_auto_reload(ar4), .o_q(q4), .o_zero(zero4), .o_busy(busy4), .o_tc_pulse(tc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic m_t step(m_t s, logic r, logic ld, logic [31:0] v, logic e, logic a);
        m_t n = s;
        n.tc = 1'b0;
        if (r) begin
            n = '0;
        end else if (ld) begin
            n.q = v; n.rl = v; n.run = (v != 0);
        end else if (s.run && e && s.q == 1) begin
            n.tc = 1'b1;
            if (a) n.q = s.rl;
            else begin n.q = 0; n.run = 1'b0; end
        end else if (s.run && e) begin
            n.q = s.q - 1;
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m8   <= step(m8, rst, load, {24'd0, lv}, en, ar);
        m4   <= step(m4, rst4, load4, {28'd0, lv4}, en4, ar4);
        m_ok <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model8_q", {24'd0, q8}, m8.q);
            chk("model8_zero", {31'd0, zero8}, {31'd0, m8.q == 0});
            chk("model8_busy", {31'd0, busy8}, {31'd0, m8.run});
            chk("model8_tc", {31'd0, tc8}, {31'd0, m8.tc});
            chk("model4_q", {28'd0, q4}, m4.q);
            chk("model4_zero", {31'd0, zero4}, {31'd0, m4.q == 0});
            chk("model4_busy", {31'd0, busy4}, {31'd0, m4.run});
            chk("model4_tc", {31'd0, tc4}, {31'd0, m4.tc});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exp8(string nm, int q, bit t, bit b);
        chk({nm, "_q"}, {24'd0, q8}, q);
        chk({nm, "_tc"}, {31'd0, tc8}, {31'd0, t});
        chk({nm, "_busy"}, {31'd0, busy8}, {31'd0, b});
        chk({nm, "_zero"}, {31'd0, zero8}, {31'd0, q == 0});
    endtask

    initial begin
        int seq_q[7];
        bit seq_e[7];
        rst = 1'b1; load = 1'b1; lv = 8'd9; en = 1'b1; ar = 1'b0;
        rst4 = 1'b1; load4 = 1'b0; lv4 = 4'd0; en4 = 1'b0; ar4 = 1'b0;
        tick(); tick();
        exp8("reset", 0, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0; en = 1'b0;

        // One-shot count from 5
        load = 1'b1; lv = 8'd5; en = 1'b1; ar = 1'b0;
        tick();
        exp8("os_load", 5, 1'b0, 1'b1);
        load = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            tick();
            exp8("os_dec", k, 1'b0, 1'b1);
        end
        tick();
        exp8("os_term", 0, 1'b1, 1'b0);
        tick();
        exp8("os_after", 0, 1'b0, 1'b0);
        tick();
        exp8("os_hold", 0, 1'b0, 1'b0);

        // Periodic count from 3, then back to one-shot
        load = 1'b1; lv = 8'd3; ar = 1'b1;
        tick();
        exp8("per_load", 3, 1'b0, 1'b1);
        load = 1'b0;
        for (int p = 0; p < 2; p++) begin
            tick(); exp8("per_2", 2, 1'b0, 1'b1);
            tick(); exp8("per_1", 1, 1'b0, 1'b1);
            tick(); exp8("per_reload", 3, 1'b1, 1'b1);
        end
        ar = 1'b0;
        tick(); exp8("per_off_2", 2, 1'b0, 1'b1);
        tick(); exp8("per_off_1", 1, 1'b0, 1'b1);
        tick(); exp8("per_off_term", 0, 1'b1, 1'b0);

        // Gated enable
        load = 1'b1; lv = 8'd4; en = 1'b1;
        tick();
        exp8("gate_load", 4, 1'b0, 1'b1);
        load = 1'b0;
        seq_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        seq_q = '{3, 3, 3, 2, 1, 1, 0};
        for (int k = 0; k < 7; k++) begin
            en = seq_e[k];
            tick();
            exp8("gate", seq_q[k], k == 6, k != 6);
        end

        // Reload at terminal count and load of zero
        load = 1'b1; lv = 8'd2; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        exp8("ld_pre", 1, 1'b0, 1'b1);
        load = 1'b1; lv = 8'd7;
        tick();
        exp8("ld_over_term", 7, 1'b0, 1'b1);
        lv = 8'd0;
        tick();
        exp8("ld_zero", 0, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        exp8("ld_zero_hold", 0, 1'b0, 1'b0);

        // Periodic N=1: pulse every enabled cycle
        load = 1'b1; lv = 8'd1; ar = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp8("n1_per", 1, 1'b1, 1'b1);
        end
        en = 1'b0;
        tick();
        exp8("n1_paused", 1, 1'b0, 1'b1);
        ar = 1'b0; en = 1'b1;
        tick();
        exp8("n1_stop", 0, 1'b1, 1'b0);

        // Mid-count reset on the 4-bit instance, then no wrap in IDLE
        rst4 = 1'b0; load4 = 1'b1; lv4 = 4'd15; en4 = 1'b1;
        tick();
        chk("w4_load", {28'd0, q4}, 32'd15);
        load4 = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("w4_at9", {28'd0, q4}, 32'd9);
        rst4 = 1'b1;
        tick();
        chk("w4_rst_q", {28'd0, q4}, 32'd0);
        chk("w4_rst_busy", {31'd0, busy4}, 32'd0);
        rst4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("w4_nowrap", {28'd0, q4}, 32'd0);
            chk("w4_nowrap_tc", {31'd0, tc4}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
